stage_calc_seq: RTL and testbench
=================================

Name: stage_calc_seq

Overview:
Parametrised tile sequencer for the stage-calc MAC array. It generalises the single-tile stage-one controller to arbitrary PE_ROW x PE_COL arrays, with shapes larger than the array tiled row-major. It drives operand-buffer reads, accumulator control, skew flush and a back-pressured result drain, with selectable output layout. It sits between the layer-control FSM (start/done) and the A/B SRAMs, the PE array and the output buffer.

Parameters:
DIM_W, 8, width of k_param/row_shape/col_shape
PE_ROW, 4, PE array rows (results per column per tile)
PE_COL, 12, PE array columns
ADDR_W, 16, width of all buffer addresses

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  begin job; sampled only in IDLE
k_param  in  DIM_W  reduction length K
row_shape  in  DIM_W  output rows M
col_shape  in  DIM_W  output cols N
out_mode  in  1  0=row-major output, 1=tile-major output
busy  out  1  high from start accept until done
done  out  1  one-cycle pulse at job end
err  out  1  sticky illegal-param flag, cleared on next accepted start
a_rd_en  out  1  A buffer read strobe
a_rd_addr  out  ADDR_W  A address
b_rd_en  out  1  B buffer read strobe
b_rd_addr  out  ADDR_W  B address
acc_clr  out  1  clear PE accumulators
acc_en  out  1  PE accumulate enable
drain_ready  in  1  output buffer can accept a row
out_wr_en  out  1  write one PE_COL-wide result row
out_wr_addr  out  ADDR_W  output row address
out_row_sel  out  log2(PE_ROW)  PE row being drained

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, err 0. Reset mid-job aborts immediately to IDLE; no done pulse is issued.
- IDLE: when start=1, latch k_param/row_shape/col_shape/out_mode and set busy=1 next cycle. start while busy is ignored.
- Illegal parameters (K, M or N = 0): go to DONE, set err=1, issue no reads or writes.
- RT = ceil(M/PE_ROW), CT = ceil(N/PE_COL). Tiles are visited rt outer, ct inner.
- Per tile:
  - CLR (1 cycle): acc_clr=1.
  - FEED (K cycles, kk=0..K-1): a_rd_en=b_rd_en=1, a_rd_addr=rt*K+kk, b_rd_addr=ct*K+kk.
  - acc_en is a_rd_en delayed by one cycle (1-cycle SRAM latency).
  - FLUSH: PE_ROW+PE_COL-1 cycles of no-op for skew drain.
  - DRAIN: r = 0 .. min(PE_ROW, M-rt*PE_ROW)-1. Rows beyond M are skipped and take no cycles.
  - out_wr_en = DRAIN && drain_ready (combinational on drain_ready). r advances only on a write; drain_ready low stalls with outputs held.
  - out_wr_addr: mode0 = (rt*PE_ROW+r)*CT+ct; mode1 = (rt*CT+ct)*PE_ROW+r. out_row_sel=r.
- After the last row of the last tile: DONE (1 cycle), done=1, busy=0, then IDLE. A start is accepted in the cycle after DONE.
- Arithmetic: addresses are computed in ADDR_W bits and wrap modulo 2^ADDR_W. Products are formed in registered counters (incremental adds, no multipliers).
- Latency per tile = 1 + K + PE_ROW+PE_COL-1 + valid_rows + stall cycles.

Optional Feature:
STAGE_CALC_PERF_EN:
- Defined: adds ports perf_cycles (out, 32) and perf_stall (out, 32). Both clear on start accept.
  - perf_cycles counts busy cycles.
  - perf_stall counts DRAIN cycles with drain_ready=0.
  - Both hold their value after done and saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- PE 4x12, K=96, M=4, N=12, mode0, drain_ready=1 -> 96 A/B reads at addr 0..95; out_wr addrs 0,1,2,3; done 116 cycles after busy rises; err=0.
- K=8, M=6, N=20, mode0 -> 4 tiles; writes per tile 4,4,2,2 (12 total); tile (1,1) addrs 9,11; skipped rows take no cycles.
- Same job in mode1 -> addrs 0-3, 4-7, 8-9, 12-13.
- K=0 start -> no reads/writes; done pulse; err=1 until next valid start clears it.
- drain_ready low for 5 cycles mid-DRAIN -> out_wr_en=0, address held, perf_stall=5 (if STAGE_CALC_PERF_EN); resumes with no lost row.
- rst asserted during FEED kk=40 -> all outputs 0 that cycle, no done; a fresh start then runs the full job correctly. start pulsed while busy -> ignored.

Source files
------------

// File: rtl/stage_calc_seq.sv
// -----------------------------------------------------------------------------
// stage_calc_seq
//
// Tile sequencer for the stage-calc MAC array. A job of shape M x N with
// reduction length K is cut into PE_ROW x PE_COL tiles visited row-major
// (row tile outer, column tile inner). For every tile the sequencer clears the
// accumulators, streams K operand reads from the A/B buffers, waits out the
// systolic skew, then drains the valid result rows to the output buffer under
// back-pressure from drain_ready.
//
// Optional build macro: STAGE_CALC_PERF_EN adds the perf_cycles/perf_stall
// performance counters and their ports.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             begin a job (sampled only while idle)
//   k_param           reduction length K
//   row_shape         output rows M
//   col_shape         output columns N
//   out_mode          0 = row-major output addressing, 1 = tile-major
//   busy              high from start accept until the job ends
//   done              one-cycle pulse at job end
//   err               sticky illegal-parameter flag (K, M or N zero)
//   a_rd_en/a_rd_addr A buffer read strobe and address
//   b_rd_en/b_rd_addr B buffer read strobe and address
//   acc_clr           clear PE accumulators
//   acc_en            PE accumulate enable (read strobe delayed one cycle)
//   drain_ready       output buffer can accept a row this cycle
//   out_wr_en         write one PE_COL-wide result row
//   out_wr_addr       output row address
//   out_row_sel       PE row being drained
//   perf_cycles       (STAGE_CALC_PERF_EN) busy cycle count, saturating
//   perf_stall        (STAGE_CALC_PERF_EN) drain stall count, saturating
// -----------------------------------------------------------------------------
module stage_calc_seq #(
    parameter int DIM_W  = 8,
    parameter int PE_ROW = 4,
    parameter int PE_COL = 12,
    parameter int ADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIM_W-1:0]     k_param,
    input  logic [DIM_W-1:0]     row_shape,
    input  logic [DIM_W-1:0]     col_shape,
    input  logic                 out_mode,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 a_rd_en,
    output logic [ADDR_W-1:0]    a_rd_addr,
    output logic                 b_rd_en,
    output logic [ADDR_W-1:0]    b_rd_addr,
    output logic                 acc_clr,
    output logic                 acc_en,
    input  logic                 drain_ready,
    output logic                 out_wr_en,
    output logic [ADDR_W-1:0]    out_wr_addr,
    output logic [((PE_ROW > 1) ? $clog2(PE_ROW) : 1)-1:0] out_row_sel
`ifdef STAGE_CALC_PERF_EN
    ,
    output logic [31:0]          perf_cycles,
    output logic [31:0]          perf_stall
`endif
);

    localparam int RSW       = (PE_ROW > 1) ? $clog2(PE_ROW) : 1;
    localparam int FLUSH_LEN = PE_ROW + PE_COL - 1;
    localparam int FLW       = $clog2(FLUSH_LEN + 1);
    // Tile base counters need headroom above DIM_W so base+tile never wraps
    // before it is compared against the shape.
    localparam int BW        = DIM_W + 2 + $clog2(PE_ROW + PE_COL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DIM_W-1:0]    k_q, k_d;
    logic [DIM_W-1:0]    m_q, m_d;
    logic [DIM_W-1:0]    n_q, n_d;
    logic                mode_q, mode_d;
    logic                err_q, err_d;
    logic                acc_en_q, acc_en_d;
    logic [DIM_W-1:0]    kk_q, kk_d;
    logic [FLW-1:0]      fl_q, fl_d;
    logic [RSW-1:0]      r_q, r_d;
    logic [BW-1:0]       rb_q, rb_d;          // rt * PE_ROW
    logic [BW-1:0]       cb_q, cb_d;          // ct * PE_COL
    logic [ADDR_W-1:0]   ct_q, ct_d;          // column tile index
    logic [ADDR_W-1:0]   ct_total_q, ct_total_d;
    logic [ADDR_W-1:0]   a_base_q, a_base_d;  // rt * K
    logic [ADDR_W-1:0]   b_base_q, b_base_d;  // ct * K
    logic [ADDR_W-1:0]   m0_base_q, m0_base_d; // rt * PE_ROW * CT
    logic [ADDR_W-1:0]   m0_row_q, m0_row_d;  // (rt * PE_ROW + r) * CT
    logic [ADDR_W-1:0]   m1_tile_q, m1_tile_d; // (rt * CT + ct) * PE_ROW

    logic illegal;
    logic last_kk;
    logic last_fl;
    logic last_row;
    logic last_ct;
    logic last_rt;

    assign illegal = (k_param == '0) || (row_shape == '0) || (col_shape == '0);
    assign last_kk = (kk_q == (k_q - DIM_W'(1)));
    assign last_fl = (fl_q == FLW'(FLUSH_LEN - 1));
    // A tile row is the last one either at the array edge or at the edge of M;
    // rows past M are never visited.
    assign last_row = (r_q == RSW'(PE_ROW - 1)) ||
                      ((rb_q + BW'(r_q) + BW'(1)) >= BW'(m_q));
    assign last_ct  = (cb_q + BW'(PE_COL)) >= BW'(n_q);
    assign last_rt  = (rb_q + BW'(PE_ROW)) >= BW'(m_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            m_q        <= '0;
            n_q        <= '0;
            mode_q     <= 1'b0;
            err_q      <= 1'b0;
            acc_en_q   <= 1'b0;
            kk_q       <= '0;
            fl_q       <= '0;
            r_q        <= '0;
            rb_q       <= '0;
            cb_q       <= '0;
            ct_q       <= '0;
            ct_total_q <= '0;
            a_base_q   <= '0;
            b_base_q   <= '0;
            m0_base_q  <= '0;
            m0_row_q   <= '0;
            m1_tile_q  <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            m_q        <= m_d;
            n_q        <= n_d;
            mode_q     <= mode_d;
            err_q      <= err_d;
            acc_en_q   <= acc_en_d;
            kk_q       <= kk_d;
            fl_q       <= fl_d;
            r_q        <= r_d;
            rb_q       <= rb_d;
            cb_q       <= cb_d;
            ct_q       <= ct_d;
            ct_total_q <= ct_total_d;
            a_base_q   <= a_base_d;
            b_base_q   <= b_base_d;
            m0_base_q  <= m0_base_d;
            m0_row_q   <= m0_row_d;
            m1_tile_q  <= m1_tile_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        m_d        = m_q;
        n_d        = n_q;
        mode_d     = mode_q;
        err_d      = err_q;
        kk_d       = kk_q;
        fl_d       = fl_q;
        r_d        = r_q;
        rb_d       = rb_q;
        cb_d       = cb_q;
        ct_d       = ct_q;
        ct_total_d = ct_total_q;
        a_base_d   = a_base_q;
        b_base_d   = b_base_q;
        m0_base_d  = m0_base_q;
        m0_row_d   = m0_row_q;
        m1_tile_d  = m1_tile_q;
        // The operand SRAM returns data one cycle after the read strobe.
        acc_en_d   = (state_q == S_FEED);

        busy        = 1'b0;
        done        = 1'b0;
        a_rd_en     = 1'b0;
        b_rd_en     = 1'b0;
        a_rd_addr   = '0;
        b_rd_addr   = '0;
        acc_clr     = 1'b0;
        out_wr_en   = 1'b0;
        out_wr_addr = '0;
        out_row_sel = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d        = k_param;
                    m_d        = row_shape;
                    n_d        = col_shape;
                    mode_d     = out_mode;
                    err_d      = illegal;
                    // Column tile count is needed by the row-major address;
                    // division by a constant elaborates to fixed logic.
                    ct_total_d = ADDR_W'((32'(col_shape) + 32'(PE_COL - 1)) / 32'(PE_COL));
                    kk_d       = '0;
                    fl_d       = '0;
                    r_d        = '0;
                    rb_d       = '0;
                    cb_d       = '0;
                    ct_d       = '0;
                    a_base_d   = '0;
                    b_base_d   = '0;
                    m0_base_d  = '0;
                    m0_row_d   = '0;
                    m1_tile_d  = '0;
                    state_d    = illegal ? S_DONE : S_CLR;
                end
            end

            S_CLR: begin
                busy     = 1'b1;
                acc_clr  = 1'b1;
                kk_d     = '0;
                m0_row_d = m0_base_q;
                state_d  = S_FEED;
            end

            S_FEED: begin
                busy      = 1'b1;
                a_rd_en   = 1'b1;
                b_rd_en   = 1'b1;
                a_rd_addr = a_base_q + ADDR_W'(kk_q);
                b_rd_addr = b_base_q + ADDR_W'(kk_q);
                kk_d      = kk_q + DIM_W'(1);
                if (last_kk) begin
                    fl_d    = '0;
                    state_d = S_FLUSH;
                end
            end

            S_FLUSH: begin
                busy = 1'b1;
                fl_d = fl_q + FLW'(1);
                if (last_fl) begin
                    r_d     = '0;
                    state_d = S_DRAIN;
                end
            end

            S_DRAIN: begin
                busy        = 1'b1;
                out_wr_en   = drain_ready;
                out_wr_addr = mode_q ? (m1_tile_q + ADDR_W'(r_q)) : (m0_row_q + ct_q);
                out_row_sel = r_q;
                if (drain_ready) begin
                    r_d      = r_q + RSW'(1);
                    m0_row_d = m0_row_q + ct_total_q;
                    if (last_row) begin
                        m1_tile_d = m1_tile_q + ADDR_W'(PE_ROW);
                        if (last_ct) begin
                            if (last_rt) begin
                                state_d = S_DONE;
                            end else begin
                                // Only the final row tile can be partial, so
                                // the running row address already sits on the
                                // next row tile's base.
                                rb_d      = rb_q + BW'(PE_ROW);
                                cb_d      = '0;
                                ct_d      = '0;
                                a_base_d  = a_base_q + ADDR_W'(k_q);
                                b_base_d  = '0;
                                m0_base_d = m0_row_q + ct_total_q;
                                state_d   = S_CLR;
                            end
                        end else begin
                            cb_d     = cb_q + BW'(PE_COL);
                            ct_d     = ct_q + ADDR_W'(1);
                            b_base_d = b_base_q + ADDR_W'(k_q);
                            state_d  = S_CLR;
                        end
                    end
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign err    = err_q;
    assign acc_en = acc_en_q;

`ifdef STAGE_CALC_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (busy && !(&perf_cycles_q)) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if ((state_q == S_DRAIN) && !drain_ready && !(&perf_stall_q)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stall  = perf_stall_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_stage_calc_seq.sv
module tb_stage_calc_seq;

    localparam int DIM_W  = 8;
    localparam int PE_ROW = 4;
    localparam int PE_COL = 12;
    localparam int ADDR_W = 16;
    localparam int FLUSH  = PE_ROW + PE_COL - 1;

    logic              clk;
    logic              rst;
    logic              start;
    logic [DIM_W-1:0]  k_param;
    logic [DIM_W-1:0]  row_shape;
    logic [DIM_W-1:0]  col_shape;
    logic              out_mode;
    logic              busy;
    logic              done;
    logic              err;
    logic              a_rd_en;
    logic [ADDR_W-1:0] a_rd_addr;
    logic              b_rd_en;
    logic [ADDR_W-1:0] b_rd_addr;
    logic              acc_clr;
    logic              acc_en;
    logic              drain_ready;
    logic              out_wr_en;
    logic [ADDR_W-1:0] out_wr_addr;
    logic [1:0]        out_row_sel;
`ifdef STAGE_CALC_PERF_EN
    logic [31:0]       perf_cycles;
    logic [31:0]       perf_stall;
`endif

    stage_calc_seq #(
        .DIM_W (DIM_W),
        .PE_ROW(PE_ROW),
        .PE_COL(PE_COL),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .k_param    (k_param),
        .row_shape  (row_shape),
        .col_shape  (col_shape),
        .out_mode   (out_mode),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .a_rd_en    (a_rd_en),
        .a_rd_addr  (a_rd_addr),
        .b_rd_en    (b_rd_en),
        .b_rd_addr  (b_rd_addr),
        .acc_clr    (acc_clr),
        .acc_en     (acc_en),
        .drain_ready(drain_ready),
        .out_wr_en  (out_wr_en),
        .out_wr_addr(out_wr_addr),
        .out_row_sel(out_row_sel)
`ifdef STAGE_CALC_PERF_EN
        ,
        .perf_cycles(perf_cycles),
        .perf_stall (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One expected cycle of the job, starting with the cycle after start accept.
    typedef struct {
        logic        busy;
        logic        done;
        logic        a_en;
        logic        acc_clr;
        logic        acc_en;
        logic        drain;
        logic        wr_en;
        logic        dr;
        logic [15:0] a_addr;
        logic [15:0] b_addr;
        logic [15:0] wr_addr;
        logic [1:0]  row_sel;
    } ent_t;

    ent_t exp_q[$];
    logic last_a;
    int   n_stall;
    int   n_busy;
    int   vectors;
    int   miscompares;
    logic prev_err;
    int   prev_cyc;
    int   prev_stall;

    function automatic ent_t blank();
        ent_t e;
        e = '{default: '0};
        e.dr = 1'($urandom_range(0, 1));
        return e;
    endfunction

    function automatic void push_ent(ent_t e);
        ent_t x;
        x = e;
        x.acc_en = last_a;
        last_a = x.a_en;
        if (x.busy) n_busy++;
        exp_q.push_back(x);
    endfunction

    // Reference: cycle-by-cycle schedule derived from the tiling rules.
    // cfg 0: drain always ready; 1: random back-pressure;
    // 2: drain_ready low for 5 cycles from the third drain cycle of tile (0,0).
    function automatic void build(int k, int m, int n, bit mode, int cfg);
        ent_t e;
        int rt_n, ct_n, vr, r, dc;
        logic dr;
        exp_q.delete();
        last_a  = 1'b0;
        n_stall = 0;
        n_busy  = 0;
        if (k == 0 || m == 0 || n == 0) begin
            e = blank();
            e.done = 1'b1;
            push_ent(e);
            return;
        end
        rt_n = (m + PE_ROW - 1) / PE_ROW;
        ct_n = (n + PE_COL - 1) / PE_COL;
        for (int rt = 0; rt < rt_n; rt++) begin
            for (int ct = 0; ct < ct_n; ct++) begin
                e = blank(); e.busy = 1'b1; e.acc_clr = 1'b1; push_ent(e);
                for (int kk = 0; kk < k; kk++) begin
                    e = blank(); e.busy = 1'b1; e.a_en = 1'b1;
                    e.a_addr = 16'(rt * k + kk);
                    e.b_addr = 16'(ct * k + kk);
                    push_ent(e);
                end
                for (int f = 0; f < FLUSH; f++) begin
                    e = blank(); e.busy = 1'b1; push_ent(e);
                end
                vr = m - rt * PE_ROW;
                if (vr > PE_ROW) vr = PE_ROW;
                r  = 0;
                dc = 0;
                while (r < vr) begin
                    e = blank(); e.busy = 1'b1; e.drain = 1'b1;
                    case (cfg)
                        1:       dr = ($urandom_range(0, 3) != 0);
                        2:       dr = !(rt == 0 && ct == 0 && dc >= 2 && dc < 7);
                        default: dr = 1'b1;
                    endcase
                    e.dr = dr;
                    e.wr_en = dr;
                    e.wr_addr = mode ? 16'((rt * ct_n + ct) * PE_ROW + r)
                                     : 16'((rt * PE_ROW + r) * ct_n + ct);
                    e.row_sel = 2'(r);
                    push_ent(e);
                    if (dr) r++;
                    else n_stall++;
                    dc++;
                end
            end
        end
        e = blank();
        e.done = 1'b1;
        push_ent(e);
    endfunction

    // Offers a job in the current idle cycle and checks every following cycle
    // against the reference schedule. abort_at >= 0 asserts rst at that cycle.
    task automatic run_job(input int k, input int m, input int n, input bit mode,
                           input int cfg, input int abort_at, input string name);
        ent_t x;
        bit   exp_err;
        build(k, m, n, mode, cfg);
        exp_err = (k == 0) || (m == 0) || (n == 0);

        start       = 1'b1;
        k_param     = 8'(k);
        row_shape   = 8'(m);
        col_shape   = 8'(n);
        out_mode    = mode;
        drain_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || out_wr_en !== 1'b0 || a_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle busy/done/wr/rd: got %b%b%b%b, required 0000",
                     name, busy, done, out_wr_en, a_rd_en);
        end
        vectors++;
        if (err !== prev_err) begin
            miscompares++;
            $display("FAIL %s idle err: got %b, required %b", name, err, prev_err);
        end
`ifdef STAGE_CALC_PERF_EN
        vectors++;
        if (perf_cycles !== 32'(prev_cyc) || perf_stall !== 32'(prev_stall)) begin
            miscompares++;
            $display("FAIL %s perf hold: got %0d/%0d, required %0d/%0d",
                     name, perf_cycles, perf_stall, prev_cyc, prev_stall);
        end
`endif
        @(posedge clk); #1;
        start     = 1'b0;
        k_param   = 8'($urandom);
        row_shape = 8'($urandom);
        col_shape = 8'($urandom);
        out_mode  = 1'($urandom);

        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            x = exp_q[i];
            drain_ready = x.dr;
            // Starts while busy and in the done cycle must be ignored.
            start = (i == 3) || x.done;
            if (i == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                vectors++;
                if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || a_rd_en !== 1'b0 ||
                    b_rd_en !== 1'b0 || a_rd_addr !== 16'd0 || b_rd_addr !== 16'd0 ||
                    acc_clr !== 1'b0 || acc_en !== 1'b0 || out_wr_en !== 1'b0 ||
                    out_wr_addr !== 16'd0 || out_row_sel !== 2'd0) begin
                    miscompares++;
                    $display("FAIL %s abort outputs: busy=%b done=%b rd=%b a=%0d acc_en=%b wr=%b, required all 0",
                             name, busy, done, a_rd_en, a_rd_addr, acc_en, out_wr_en);
                end
                @(posedge clk); #1;
                rst   = 1'b0;
                start = 1'b0;
                repeat (8) begin
                    @(negedge clk);
                    vectors++;
                    if (busy !== 1'b0 || done !== 1'b0) begin
                        miscompares++;
                        $display("FAIL %s after abort busy/done: got %b%b, required 00",
                                 name, busy, done);
                    end
                    @(posedge clk); #1;
                end
                prev_err   = 1'b0;
                prev_cyc   = 0;
                prev_stall = 0;
                return;
            end
            @(negedge clk);
            vectors++;
            if (busy !== x.busy || done !== x.done) begin
                miscompares++;
                $display("FAIL %s[%0d] busy/done: got %b%b, required %b%b",
                         name, i, busy, done, x.busy, x.done);
            end
            vectors++;
            if (err !== exp_err) begin
                miscompares++;
                $display("FAIL %s[%0d] err: got %b, required %b", name, i, err, exp_err);
            end
            vectors++;
            if (a_rd_en !== x.a_en || b_rd_en !== x.a_en) begin
                miscompares++;
                $display("FAIL %s[%0d] rd_en a/b: got %b%b, required %b",
                         name, i, a_rd_en, b_rd_en, x.a_en);
            end
            if (x.a_en) begin
                vectors++;
                if (a_rd_addr !== x.a_addr || b_rd_addr !== x.b_addr) begin
                    miscompares++;
                    $display("FAIL %s[%0d] rd_addr a/b: got %0d/%0d, required %0d/%0d",
                             name, i, a_rd_addr, b_rd_addr, x.a_addr, x.b_addr);
                end
            end
            vectors++;
            if (acc_clr !== x.acc_clr || acc_en !== x.acc_en) begin
                miscompares++;
                $display("FAIL %s[%0d] acc_clr/acc_en: got %b%b, required %b%b",
                         name, i, acc_clr, acc_en, x.acc_clr, x.acc_en);
            end
            vectors++;
            if (out_wr_en !== x.wr_en) begin
                miscompares++;
                $display("FAIL %s[%0d] out_wr_en: got %b, required %b", name, i, out_wr_en, x.wr_en);
            end
            if (x.drain) begin
                vectors++;
                if (out_wr_addr !== x.wr_addr || out_row_sel !== x.row_sel) begin
                    miscompares++;
                    $display("FAIL %s[%0d] out_wr_addr/row_sel: got %0d/%0d, required %0d/%0d",
                             name, i, out_wr_addr, out_row_sel, x.wr_addr, x.row_sel);
                end
            end
        end
        @(posedge clk); #1;
        start      = 1'b0;
        prev_err   = exp_err;
        prev_cyc   = n_busy;
        prev_stall = n_stall;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        start       = 1'b0;
        k_param     = '0;
        row_shape   = '0;
        col_shape   = '0;
        out_mode    = 1'b0;
        drain_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || a_rd_en !== 1'b0 ||
            b_rd_en !== 1'b0 || a_rd_addr !== 16'd0 || b_rd_addr !== 16'd0 ||
            acc_clr !== 1'b0 || acc_en !== 1'b0 || out_wr_en !== 1'b0 ||
            out_wr_addr !== 16'd0 || out_row_sel !== 2'd0) begin
            miscompares++;
            $display("FAIL reset outputs: busy=%b done=%b err=%b rd=%b wr=%b, required all 0",
                     busy, done, err, a_rd_en, out_wr_en);
        end
`ifdef STAGE_CALC_PERF_EN
        vectors++;
        if (perf_cycles !== 32'd0 || perf_stall !== 32'd0) begin
            miscompares++;
            $display("FAIL reset perf: got %0d/%0d, required 0/0", perf_cycles, perf_stall);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        prev_err   = 1'b0;
        prev_cyc   = 0;
        prev_stall = 0;
    endtask

    task automatic test_single_tile();
        run_job(96, 4, 12, 1'b0, 0, -1, "single_tile");
    endtask

    task automatic test_tiled_modes();
        run_job(8, 6, 20, 1'b0, 0, -1, "tiled_mode0");
        run_job(8, 6, 20, 1'b1, 0, -1, "tiled_mode1");
    endtask

    task automatic test_illegal();
        run_job(0, 5, 5, 1'b0, 0, -1, "illegal_k");
        run_job(3, 0, 7, 1'b0, 0, -1, "illegal_m");
        run_job(3, 7, 0, 1'b1, 0, -1, "illegal_n");
        run_job(3, 2, 2, 1'b0, 0, -1, "after_illegal");
    endtask

    task automatic test_stall();
        run_job(8, 6, 20, 1'b0, 2, -1, "stall5");
`ifdef STAGE_CALC_PERF_EN
        vectors++;
        if (prev_stall != 5) begin
            miscompares++;
            $display("FAIL stall5 model stall count: got %0d, required 5", prev_stall);
        end
`endif
    endtask

    task automatic test_reset_midjob();
        run_job(96, 4, 12, 1'b0, 0, 41, "abort_feed");
        run_job(96, 4, 12, 1'b0, 0, -1, "after_abort");
    endtask

    task automatic test_random();
        for (int j = 0; j < 8; j++) begin
            run_job($urandom_range(1, 20), $urandom_range(1, 12), $urandom_range(1, 40),
                    1'($urandom_range(0, 1)), 1, -1, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_job(2, 3, 13, 1'b1, 1, -1, "b2b_0");
        run_job(1, 9, 5, 1'b0, 1, -1, "b2b_1");
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL final idle busy/done/err: got %b%b%b, required 000", busy, done, err);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_tile();
        test_tiled_modes();
        test_illegal();
        test_stall();
        test_reset_midjob();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
